hazard_ctrl: RTL and testbench

- Hazard detection and stall/flush controller for the 5-stage MIPS pipeline.
- Produces the bubble-select (ID_EX_Mux) consumed by the ID/EX pipeline register, plus PC/IF-ID write enables and flush strobes.
- Detects load-use hazards from the ID/EX outputs against the instruction in decode, and holds a parameterised multi-cycle stall.
- Squashes younger instructions on a taken branch.

---
 rtl/hazard_ctrl_pkg.sv | 15 +
 rtl/hazard_cmp.sv | 26 ++
 rtl/hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t  : controller state encoding (RUN / STALL)
//   REG_ZERO : architectural $0, which is hard-wired to zero and never a hazard
//   PERF_W   : width of the optional performance counters
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         PERF_W   = 32;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator. Flags when the load currently in EX writes a register
// that the instruction in decode reads.
// Ports:
//   memRead      : EX-stage instruction is a load
//   regWriteAdd  : EX-stage destination register
//   regAdd1      : decode rs
//   regAdd2      : decode rt
//   usesRt       : decode instruction actually reads rt
//   hz           : load-use hazard present
module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic       memRead,
  input  logic [4:0] regWriteAdd,
  input  logic [4:0] regAdd1,
  input  logic [4:0] regAdd2,
  input  logic       usesRt,
  output logic       hz
);

  // Writes to $0 are discarded by the register file, so they cannot feed a
  // stale value to the consumer.
  assign hz = memRead && (regWriteAdd != REG_ZERO) &&
              ((regWriteAdd == regAdd1) || (usesRt && (regWriteAdd == regAdd2)));

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection and stall/flush controller for the 5-stage MIPS pipeline.
// State updates on the falling clock edge, like the pipeline registers.
// Optional macro HAZARD_PERF_CNT_EN adds saturating performance counters.
// Ports:
//   clk, rst          : pipeline clock; asynchronous active-low reset
//   ID_RegAdd1/2      : rs / rt of the instruction in decode
//   ID_UsesRt         : decode instruction reads rt
//   EX_MemRead        : ID/EX MemRead
//   EX_RegWriteAdd    : destination register of the instruction in EX
//   MEM_BranchTaken   : branch resolved taken in MEM (one-cycle pulse)
//   PC_Write          : PC update enable
//   IF_ID_Write       : IF/ID update enable
//   IF_ID_Flush       : zero the IF/ID instruction
//   ID_EX_Mux         : bubble select into ID/EX (1 zeros control)
//   EX_MEM_Flush      : zero EX/MEM control
//   Stalling          : controller is in the STALL state
//   StallCycles_Out   : (macro) cycles with PC_Write low
//   LoadUse_Out       : (macro) load-use hazard entries
//   Flush_Out         : (macro) taken-branch flushes
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_RegAdd1,
  input  logic [4:0] ID_RegAdd2,
  input  logic       ID_UsesRt,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_RegWriteAdd,
  input  logic       MEM_BranchTaken,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Mux,
  output logic       EX_MEM_Flush,
  output logic       Stalling
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] StallCycles_Out,
  output logic [PERF_W-1:0] LoadUse_Out,
  output logic [PERF_W-1:0] Flush_Out
`endif
);

  // The first bubble is issued from RUN, so STALL covers the remaining ones.
  localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(LOAD_STALL_CYCLES - 1);

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             hz;

  hazard_cmp uCmp (
    .memRead     (EX_MemRead),
    .regWriteAdd (EX_RegWriteAdd),
    .regAdd1     (ID_RegAdd1),
    .regAdd2     (ID_RegAdd2),
    .usesRt      (ID_UsesRt),
    .hz          (hz)
  );

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Mux    = 1'b0;
    EX_MEM_Flush = 1'b0;
    Stalling     = 1'b0;
    // While reset is held, outputs stay at their reset values even if the
    // decode inputs still show a hazard.
    if (rst) begin
      Stalling = (state == STALL);
      if (MEM_BranchTaken) begin
        // Taken branch wins: squash the younger instructions and let the PC
        // load the target, abandoning any stall in progress.
        IF_ID_Flush  = 1'b1;
        ID_EX_Mux    = 1'b1;
        EX_MEM_Flush = 1'b1;
        stateNext    = RUN;
        cntNext      = '0;
      end else if (state == STALL) begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Mux   = 1'b1;
        cntNext     = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          stateNext = RUN;
        end
      end else if (hz) begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Mux   = 1'b1;
        if (LOAD_STALL_CYCLES > 1) begin
          stateNext = STALL;
          cntNext   = STALL_LOAD;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [PERF_W-1:0] satInc(input logic [PERF_W-1:0] v);
    return (v == '1) ? v : v + PERF_W'(1);
  endfunction

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      StallCycles_Out <= '0;
      LoadUse_Out     <= '0;
      Flush_Out       <= '0;
    end else begin
      if (!PC_Write) begin
        StallCycles_Out <= satInc(StallCycles_Out);
      end
      if ((state == RUN) && hz && !MEM_BranchTaken) begin
        LoadUse_Out <= satInc(LoadUse_Out);
      end
      if (MEM_BranchTaken) begin
        Flush_Out <= satInc(Flush_Out);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  // Output vectors are {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Mux, EX_MEM_Flush, Stalling}
  localparam logic [5:0] NRM = 6'b110000;  // running normally
  localparam logic [5:0] STL = 6'b000100;  // bubble issued from RUN
  localparam logic [5:0] STS = 6'b000101;  // bubble issued from STALL
  localparam logic [5:0] BR  = 6'b111110;  // taken branch in RUN
  localparam logic [5:0] BRS = 6'b111111;  // taken branch while in STALL

  typedef struct packed {
    logic       mr;
    logic [4:0] wa;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ut;
    logic       br;
    logic [5:0] e1;
    logic [5:0] e3;
  } stim_t;

  typedef struct packed {
    logic [5:0] e1;
    logic [5:0] e3;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [4:0] rs, rt, wa;
  logic       ut, mr, br;

  logic pcw1, ifw1, iff1, mux1, exf1, stl1;
  logic pcw3, ifw3, iff3, mux3, exf3, stl3;
  logic [5:0] o1, o3;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc1, lu1, fl1, sc3, lu3, fl3;
`endif

  exp_t sb[$];
  exp_t e;
  int   compared   = 0;
  int   mismatched = 0;

  assign o1 = {pcw1, ifw1, iff1, mux1, exf1, stl1};
  assign o3 = {pcw3, ifw3, iff3, mux3, exf3, stl3};

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst),
    .ID_RegAdd1(rs), .ID_RegAdd2(rt), .ID_UsesRt(ut),
    .EX_MemRead(mr), .EX_RegWriteAdd(wa), .MEM_BranchTaken(br),
    .PC_Write(pcw1), .IF_ID_Write(ifw1), .IF_ID_Flush(iff1),
    .ID_EX_Mux(mux1), .EX_MEM_Flush(exf1), .Stalling(stl1)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCycles_Out(sc1), .LoadUse_Out(lu1), .Flush_Out(fl1)
`endif
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) u3 (
    .clk(clk), .rst(rst),
    .ID_RegAdd1(rs), .ID_RegAdd2(rt), .ID_UsesRt(ut),
    .EX_MemRead(mr), .EX_RegWriteAdd(wa), .MEM_BranchTaken(br),
    .PC_Write(pcw3), .IF_ID_Write(ifw3), .IF_ID_Flush(iff3),
    .ID_EX_Mux(mux3), .EX_MEM_Flush(exf3), .Stalling(stl3)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCycles_Out(sc3), .LoadUse_Out(lu3), .Flush_Out(fl3)
`endif
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic stim_t mk(logic m, logic [4:0] w, logic [4:0] a, logic [4:0] b,
                               logic u, logic t, logic [5:0] x1, logic [5:0] x3);
    stim_t s;
    s.mr = m; s.wa = w; s.rs = a; s.rt = b; s.ut = u; s.br = t; s.e1 = x1; s.e3 = x3;
    return s;
  endfunction

  // Applies one cycle of inputs just after the falling (state) edge and
  // records what both controllers must show during that cycle.
  task automatic drive(input stim_t s);
    @(negedge clk);
    #1;
    mr = s.mr; wa = s.wa; rs = s.rs; rt = s.rt; ut = s.ut; br = s.br;
    sb.push_back('{e1: s.e1, e3: s.e3});
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mr = 1'b1; wa = 5'd2; rs = 5'd2; rt = 5'd0; ut = 1'b0; br = 1'b0;
    repeat (3) @(negedge clk);
    sb.push_back('{e1: NRM, e3: NRM});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compared++;
    if (o1 !== e.e1) begin mismatched++; $display("FAIL reset dut1: got %b want %b", o1, e.e1); end
    compared++;
    if (o3 !== e.e3) begin mismatched++; $display("FAIL reset dut3: got %b want %b", o3, e.e3); end
`ifdef HAZARD_PERF_CNT_EN
    compared++;
    if ({sc3, lu3, fl3} !== 96'd0) begin
      mismatched++; $display("FAIL reset_counters: got %h want 0", {sc3, lu3, fl3});
    end
`endif
    mr = 1'b0; wa = 5'd0; rs = 5'd0;
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    stim_t s[4];
    s[0] = mk(1, 5'd2, 5'd2, 5'd7, 0, 0, STL, STL);
    s[1] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, NRM, STS);
    s[2] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, NRM, STS);
    s[3] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, NRM, NRM);
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compared++;
      if (o1 !== e.e1) begin mismatched++; $display("FAIL load_use[%0d] dut1: got %b want %b", i, o1, e.e1); end
      compared++;
      if (o3 !== e.e3) begin mismatched++; $display("FAIL load_use[%0d] dut3: got %b want %b", i, o3, e.e3); end
    end
`ifdef HAZARD_PERF_CNT_EN
    compared++;
    if (sc3 !== 32'd3) begin mismatched++; $display("FAIL stall_cycles dut3: got %0d want 3", sc3); end
    compared++;
    if (lu3 !== 32'd1) begin mismatched++; $display("FAIL load_use_cnt dut3: got %0d want 1", lu3); end
`endif
  endtask

  task automatic test_rt();
    stim_t s[5];
    s[0] = mk(1, 5'd2, 5'd3, 5'd2, 0, 0, NRM, NRM);
    s[1] = mk(1, 5'd2, 5'd3, 5'd2, 1, 0, STL, STL);
    s[2] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, NRM, STS);
    s[3] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, NRM, STS);
    s[4] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, NRM, NRM);
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compared++;
      if (o1 !== e.e1) begin mismatched++; $display("FAIL rt[%0d] dut1: got %b want %b", i, o1, e.e1); end
      compared++;
      if (o3 !== e.e3) begin mismatched++; $display("FAIL rt[%0d] dut3: got %b want %b", i, o3, e.e3); end
    end
  endtask

  task automatic test_reg_zero();
    stim_t s[3];
    s[0] = mk(1, 5'd0, 5'd0, 5'd0, 1, 0, NRM, NRM);
    s[1] = mk(0, 5'd9, 5'd9, 5'd9, 1, 0, NRM, NRM);
    s[2] = mk(1, 5'd9, 5'd8, 5'd10, 1, 0, NRM, NRM);
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compared++;
      if (o1 !== e.e1) begin mismatched++; $display("FAIL reg_zero[%0d] dut1: got %b want %b", i, o1, e.e1); end
      compared++;
      if (o3 !== e.e3) begin mismatched++; $display("FAIL reg_zero[%0d] dut3: got %b want %b", i, o3, e.e3); end
    end
  endtask

  task automatic test_branch();
    stim_t s[5];
    s[0] = mk(1, 5'd5, 5'd5, 5'd0, 0, 0, STL, STL);
    s[1] = mk(0, 5'd0, 5'd0, 5'd0, 0, 1, BR,  BRS);
    s[2] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, NRM, NRM);
    s[3] = mk(1, 5'd5, 5'd5, 5'd0, 0, 1, BR,  BR);
    s[4] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, NRM, NRM);
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compared++;
      if (o1 !== e.e1) begin mismatched++; $display("FAIL branch[%0d] dut1: got %b want %b", i, o1, e.e1); end
      compared++;
      if (o3 !== e.e3) begin mismatched++; $display("FAIL branch[%0d] dut3: got %b want %b", i, o3, e.e3); end
    end
  endtask

  // Hazard kept asserted through the stall: dut1 re-stalls, dut3 ignores it.
  task automatic test_back_to_back();
    stim_t s[4];
    s[0] = mk(1, 5'd6, 5'd1, 5'd6, 1, 0, STL, STL);
    s[1] = mk(1, 5'd6, 5'd1, 5'd6, 1, 0, STL, STS);
    s[2] = mk(1, 5'd6, 5'd1, 5'd6, 1, 0, STL, STS);
    s[3] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, NRM, NRM);
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compared++;
      if (o1 !== e.e1) begin mismatched++; $display("FAIL back_to_back[%0d] dut1: got %b want %b", i, o1, e.e1); end
      compared++;
      if (o3 !== e.e3) begin mismatched++; $display("FAIL back_to_back[%0d] dut3: got %b want %b", i, o3, e.e3); end
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t s[2];
    s[0] = mk(1, 5'd5, 5'd5, 5'd0, 0, 0, STL, STL);
    s[1] = mk(1, 5'd5, 5'd5, 5'd0, 0, 0, STL, STS);
    for (int i = 0; i < 2; i++) begin
      drive(s[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compared++;
      if (o1 !== e.e1) begin mismatched++; $display("FAIL pre_reset[%0d] dut1: got %b want %b", i, o1, e.e1); end
      compared++;
      if (o3 !== e.e3) begin mismatched++; $display("FAIL pre_reset[%0d] dut3: got %b want %b", i, o3, e.e3); end
    end
    // Assert reset between edges with the hazard still present.
    rst = 1'b0;
    sb.push_back('{e1: NRM, e3: NRM});
    #1;
    e = sb.pop_front();
    compared++;
    if (o1 !== e.e1) begin mismatched++; $display("FAIL async_reset dut1: got %b want %b", o1, e.e1); end
    compared++;
    if (o3 !== e.e3) begin mismatched++; $display("FAIL async_reset dut3: got %b want %b", o3, e.e3); end
    @(negedge clk);
    #2;
    mr = 1'b0; wa = 5'd0; rs = 5'd0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, NRM, NRM));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compared++;
      if (o1 !== e.e1) begin mismatched++; $display("FAIL post_reset[%0d] dut1: got %b want %b", i, o1, e.e1); end
      compared++;
      if (o3 !== e.e3) begin mismatched++; $display("FAIL post_reset[%0d] dut3: got %b want %b", i, o3, e.e3); end
    end
  endtask

  initial begin
    rst = 1'b0;
    mr = 1'b0; wa = 5'd0; rs = 5'd0; rt = 5'd0; ut = 1'b0; br = 1'b0;
    test_reset();
    test_load_use();
    test_rt();
    test_reg_zero();
    test_branch();
    test_back_to_back();
    test_reset_mid_stall();
    compared++;
    if (sb.size() != 0) begin
      mismatched++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
